// File: rtl/a_rf_pkg.sv
// Shared types and constants for the A-port register-file sequencer.
// Optional feature macro used by the top: A_SEQ_STALL_EN (adds rd_ready).
package a_rf_pkg;

  localparam int RF_SIZE = 8;
  localparam int A_WIDTH = 27;
  localparam int PASS_W  = 8;
  localparam int ADDR_W  = $clog2(RF_SIZE);
  localparam int DEPTH_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, READ, FIN} state_e;

  typedef logic [DEPTH_W-1:0] depth_t;
  typedef logic [PASS_W-1:0]  pass_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  // A requested depth of 0, or one larger than the register file, means "full".
  function automatic depth_t clamp_depth(input depth_t d);
    if (d == '0 || int'(d) > RF_SIZE) return depth_t'(RF_SIZE);
    return d;
  endfunction

endpackage

// File: rtl/a_rf_addr_gen.sv
// Read-address sweep generator: walks oldest-to-newest over the loaded window
// (step 1, or step 2 in dual-lane mode) and repeats the sweep for every pass.
module a_rf_addr_gen
  import a_rf_pkg::*;
(
  input  logic   CLK,
  input  logic   RSTN,
  input  logic   init,
  input  logic   advance,
  input  depth_t depth,
  input  pass_t  passes,
  input  logic   mdr,
  output addr_t  r_addr,
  output logic   last_beat
);

  pass_t pass_cnt;
  addr_t start_addr;
  addr_t step;

  // Oldest word sits at D-1; in dual-lane mode the pair (D-2, D-1) is read first.
  assign start_addr = addr_t'(depth - (mdr ? depth_t'(2) : depth_t'(1)));
  assign step       = mdr ? addr_t'(2) : addr_t'(1);
  assign last_beat  = (r_addr == '0) && (pass_cnt == passes - pass_t'(1));

  // Address and pass counters; they move only on a completed read beat.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_addr   <= '0;
      pass_cnt <= '0;
    end else if (init) begin
      r_addr   <= start_addr;
      pass_cnt <= '0;
    end else if (advance) begin
      if (r_addr != '0) begin
        r_addr <= r_addr - step;
      end else if (last_beat) begin
        pass_cnt <= '0;
      end else begin
        r_addr   <= start_addr;
        pass_cnt <= pass_cnt + pass_t'(1);
      end
    end
  end

endmodule

// File: rtl/a_rf_sequencer.sv
// A-port operand register-file sequencer: loads D operands from a valid/ready
// stream into the shift register file, then sweeps read addresses P times.
// Build option: define A_SEQ_STALL_EN to add rd_ready back-pressure on reads.
module a_rf_sequencer
  import a_rf_pkg::*;
(
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               cfg_start,
  input  logic [3:0]         cfg_depth,
  input  logic [PASS_W-1:0]  cfg_passes,
  input  logic               cfg_mdr,
  input  logic               s_valid,
  input  logic [A_WIDTH-1:0] s_data,
`ifdef A_SEQ_STALL_EN
  input  logic               rd_ready,
`endif
  output logic               s_ready,
  output logic               RF_load,
  output logic [A_WIDTH-1:0] A,
  output logic               MDRr,
  output logic [ADDR_W-1:0]  r_addr,
  output logic               rd_valid,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  state_e state;
  depth_t depth_q;
  pass_t  passes_q;
  logic   mdr_q;
  depth_t load_cnt;
  depth_t start_depth;
  logic   advance;
  logic   last_beat;
  logic   init;

  assign start_depth = clamp_depth(cfg_depth);

`ifdef A_SEQ_STALL_EN
  assign advance = rd_valid & rd_ready;
`else
  assign advance = rd_valid;
`endif

  // Loading is finished once s_ready has dropped; that cycle arms the sweep.
  assign init = (state == LOAD) && !s_ready && (passes_q != '0);

  a_rf_addr_gen u_addr_gen (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .init      (init),
    .advance   (advance),
    .depth     (depth_q),
    .passes    (passes_q),
    .mdr       (mdr_q),
    .r_addr    (r_addr),
    .last_beat (last_beat)
  );

  // Control FSM plus the load path; every output is a register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= IDLE;
      depth_q  <= '0;
      passes_q <= '0;
      mdr_q    <= 1'b0;
      load_cnt <= '0;
      s_ready  <= 1'b0;
      RF_load  <= 1'b0;
      A        <= '0;
      MDRr     <= 1'b0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first make the pulses one cycle wide; any
      // branch below overrides them and every read sees pre-edge values.
      RF_load <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            // Dual lane reads pairs, so an odd window (including 1) cannot be swept.
            if (cfg_mdr && start_depth[0]) begin
              cfg_err <= 1'b1;
            end else begin
              depth_q  <= start_depth;
              passes_q <= cfg_passes;
              mdr_q    <= cfg_mdr;
              load_cnt <= '0;
              s_ready  <= 1'b1;
              busy     <= 1'b1;
              state    <= LOAD;
            end
          end
        end
        LOAD: begin
          if (s_ready) begin
            if (s_valid) begin
              RF_load  <= 1'b1;
              A        <= s_data;
              load_cnt <= load_cnt + depth_t'(1);
              if (load_cnt == depth_q - depth_t'(1)) s_ready <= 1'b0;
            end
          end else if (passes_q == '0) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            rd_valid <= 1'b1;
            MDRr     <= mdr_q;
            state    <= READ;
          end
        end
        READ: begin
          if (advance && last_beat) begin
            rd_valid <= 1'b0;
            MDRr     <= 1'b0;
            done     <= 1'b1;
            state    <= FIN;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a_rf_sequencer.sv
// Self-checking bench for a_rf_sequencer. Each run precomputes the complete
// expected output trace from the sequencing rules, then drives and compares.
module tb_a_rf_sequencer;
  import a_rf_pkg::*;

  localparam int MAXC = 256;

  logic               CLK = 1'b0;
  logic               RSTN = 1'b0;
  logic               cfg_start = 1'b0;
  logic [3:0]         cfg_depth = '0;
  logic [PASS_W-1:0]  cfg_passes = '0;
  logic               cfg_mdr = 1'b0;
  logic               s_valid = 1'b0;
  logic [A_WIDTH-1:0] s_data = '0;
`ifdef A_SEQ_STALL_EN
  logic               rd_ready = 1'b1;
`endif
  logic               s_ready;
  logic               RF_load;
  logic [A_WIDTH-1:0] A;
  logic               MDRr;
  logic [ADDR_W-1:0]  r_addr;
  logic               rd_valid;
  logic               busy;
  logic               done;
  logic               cfg_err;

  a_rf_sequencer dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .cfg_start  (cfg_start),
    .cfg_depth  (cfg_depth),
    .cfg_passes (cfg_passes),
    .cfg_mdr    (cfg_mdr),
    .s_valid    (s_valid),
    .s_data     (s_data),
`ifdef A_SEQ_STALL_EN
    .rd_ready   (rd_ready),
`endif
    .s_ready    (s_ready),
    .RF_load    (RF_load),
    .A          (A),
    .MDRr       (MDRr),
    .r_addr     (r_addr),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  logic [A_WIDTH-1:0] a_last = '0;

  // Expected trace, indexed by cycle after the start pulse was sampled.
  bit                 e_sready [MAXC];
  bit                 e_load   [MAXC];
  logic [A_WIDTH-1:0] e_a      [MAXC];
  bit                 e_rd     [MAXC];
  int                 e_addr   [MAXC];
  bit                 e_mdr    [MAXC];
  bit                 e_done   [MAXC];
  bit                 e_busy   [MAXC];
  bit                 sv       [MAXC];
  logic [A_WIDTH-1:0] sd       [MAXC];
  bit                 rdy      [MAXC];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".s_ready"},  32'(s_ready),  32'd0);
    check({name, ".rf_load"},  32'(RF_load),  32'd0);
    check({name, ".a"},        32'(A),        32'd0);
    check({name, ".mdrr"},     32'(MDRr),     32'd0);
    check({name, ".r_addr"},   32'(r_addr),   32'd0);
    check({name, ".rd_valid"}, 32'(rd_valid), 32'd0);
    check({name, ".busy"},     32'(busy),     32'd0);
    check({name, ".done"},     32'(done),     32'd0);
    check({name, ".cfg_err"},  32'(cfg_err),  32'd0);
  endtask

  // vmode: 0 always valid, 1 alternating 1,0,1,..., 2 random.
  // smode: 0 never stall, 1 three stall cycles at address 2, 2 random stalls.
  task automatic run(input string name, input int draw, input int passes, input bit mdr,
                     input int vmode, input int smode, input bit seq_data,
                     input bit poke_start, input bit abort2);
    int d, len, step, beats, last, c, idx, done_c, stalled, endc;
    int addrs[$];
    logic [A_WIDTH-1:0] a_cur;

    d = (draw == 0 || draw > RF_SIZE) ? RF_SIZE : draw;
    for (int i = 0; i < MAXC; i++) begin
      e_sready[i] = 0; e_load[i] = 0; e_a[i] = '0; e_rd[i] = 0; e_addr[i] = 0;
      e_mdr[i] = 0; e_done[i] = 0; e_busy[i] = 0; rdy[i] = 1;
      sv[i] = (vmode == 0) ? 1'b1 : (vmode == 1) ? (i % 2 == 0) : ($urandom_range(0, 99) < 60);
      sd[i] = seq_data ? A_WIDTH'(32'h11 * (i + 1)) : A_WIDTH'($urandom);
    end

    // Load phase: ready until D beats accepted; each beat shows up one cycle later.
    beats = 0;
    c = 0;
    while (beats < d) begin
      e_sready[c] = 1;
      if (sv[c]) begin
        e_load[c+1] = 1;
        e_a[c+1]    = sd[c];
        beats++;
      end
      c++;
    end
    last = c;

    // Read phase: P back-to-back sweeps, oldest entry first.
    step = mdr ? 2 : 1;
    len  = mdr ? d / 2 : d;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < len; i++) addrs.push_back(d - step - i * step);
    c = last + 1;
    idx = 0;
    stalled = 0;
    while (idx < addrs.size()) begin
      e_rd[c]   = 1;
      e_addr[c] = addrs[idx];
      e_mdr[c]  = mdr;
      if (smode == 1) begin
        rdy[c] = !(addrs[idx] == 2 && stalled < 3);
        if (!rdy[c]) stalled++;
      end else if (smode == 2) begin
        rdy[c] = ($urandom_range(0, 2) != 0);
      end
      if (rdy[c]) idx++;
      c++;
    end
    done_c = c;
    e_done[done_c] = 1;
    for (int i = 0; i <= done_c; i++) e_busy[i] = 1;
    endc = done_c + 3;

    a_cur = a_last;
    for (int i = 0; i <= endc; i++) begin
      if (e_load[i]) a_cur = e_a[i];
      e_a[i] = a_cur;
    end

    @(posedge CLK); #1;
    cfg_start  = 1'b1;
    cfg_depth  = draw[3:0];
    cfg_passes = passes[PASS_W-1:0];
    cfg_mdr    = mdr;
    s_valid    = 1'b0;
    for (int k = 0; k <= endc; k++) begin
      @(posedge CLK); #1;
      cfg_start = poke_start && (k == 2);
      if (poke_start && k == 2) begin
        cfg_depth  = 4'd2;
        cfg_passes = 8'd9;
        cfg_mdr    = ~mdr;
      end
      s_valid = sv[k];
      s_data  = sd[k];
`ifdef A_SEQ_STALL_EN
      rd_ready = rdy[k];
`endif
      @(negedge CLK);
      check($sformatf("%s.s_ready@%0d", name, k),  32'(s_ready),  32'(e_sready[k]));
      check($sformatf("%s.rf_load@%0d", name, k),  32'(RF_load),  32'(e_load[k]));
      check($sformatf("%s.a@%0d", name, k),        32'(A),        32'(e_a[k]));
      check($sformatf("%s.rd_valid@%0d", name, k), 32'(rd_valid), 32'(e_rd[k]));
      check($sformatf("%s.done@%0d", name, k),     32'(done),     32'(e_done[k]));
      check($sformatf("%s.busy@%0d", name, k),     32'(busy),     32'(e_busy[k]));
      check($sformatf("%s.cfg_err@%0d", name, k),  32'(cfg_err),  32'd0);
      if (e_rd[k]) begin
        check($sformatf("%s.r_addr@%0d", name, k), 32'(r_addr), 32'(e_addr[k]));
        check($sformatf("%s.mdrr@%0d", name, k),   32'(MDRr),   32'(e_mdr[k]));
      end
      if (abort2 && e_rd[k] && e_addr[k] == 2) begin
        #1 RSTN = 1'b0;
        #1 check_all_zero({name, ".async"});
        s_valid = 1'b0;
        a_last  = '0;
        for (int j = 0; j < 3; j++) begin
          @(negedge CLK);
          check($sformatf("%s.no_done@%0d", name, j), 32'(done), 32'd0);
          check($sformatf("%s.no_busy@%0d", name, j), 32'(busy), 32'd0);
        end
        RSTN = 1'b1;
        return;
      end
    end
    a_last  = a_cur;
    s_valid = 1'b0;
  endtask

  task automatic reject(input string name, input int draw);
    @(posedge CLK); #1;
    cfg_start  = 1'b1;
    cfg_depth  = draw[3:0];
    cfg_passes = 8'd1;
    cfg_mdr    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      cfg_start = 1'b0;
      s_valid   = 1'b1;
      @(negedge CLK);
      check($sformatf("%s.cfg_err@%0d", name, k),  32'(cfg_err),  32'(k == 0));
      check($sformatf("%s.busy@%0d", name, k),     32'(busy),     32'd0);
      check($sformatf("%s.s_ready@%0d", name, k),  32'(s_ready),  32'd0);
      check($sformatf("%s.rf_load@%0d", name, k),  32'(RF_load),  32'd0);
      check($sformatf("%s.rd_valid@%0d", name, k), 32'(rd_valid), 32'd0);
    end
    s_valid = 1'b0;
  endtask

  initial begin
    int draw, dcl, np;
    bit m;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RSTN = 1'b1;
    @(negedge CLK);
    check_all_zero("idle");

    run("load_single", 4, 1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    run("dual_2pass",  8, 2, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    run("gap_p0",      3, 0, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0);
    run("clamp_0",     0, 1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    run("clamp_12",   12, 1, 1'b1, 2, 0, 1'b0, 1'b0, 1'b0);
    reject("rej_5", 5);
    reject("rej_1", 1);
    run("ign_start",   4, 2, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    run("abort",       4, 1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    run("after_abort", 2, 1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
`ifdef A_SEQ_STALL_EN
    run("stall3",      4, 1, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0);
    run("stall_rand",  8, 2, 1'b1, 2, 2, 1'b0, 1'b0, 1'b0);
`endif

    for (int t = 0; t < 24; t++) begin
      draw = $urandom_range(0, 15);
      m    = 1'($urandom_range(0, 1));
      np   = $urandom_range(0, 3);
      dcl  = (draw == 0 || draw > RF_SIZE) ? RF_SIZE : draw;
      if (m && (dcl % 2 == 1)) begin
        reject($sformatf("rnd%0d_rej", t), draw);
      end else begin
`ifdef A_SEQ_STALL_EN
        run($sformatf("rnd%0d", t), draw, np, m, 2, 2, 1'b0, 1'b0, 1'b0);
`else
        run($sformatf("rnd%0d", t), draw, np, m, 2, 0, 1'b0, 1'b0, 1'b0);
`endif
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
